fetch_queue_nw: RTL

Parametrised N-wide instruction fetch queue. It generalises the fixed two-port (a/b) imem fetch to WIDTH instructions per cycle and decouples fetch from decode. Each cycle it fetches WIDTH consecutive instructions into a circular buffer and presents the oldest WIDTH entries to decode. Decode consumes a variable number (0..WIDTH) per cycle, so a hazard on lane k stalls lanes k and above without losing instructions. Sits between the imem and the F/D latch.

---
 rtl/fetch_queue_nw.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_queue_nw.sv
// fetch_queue_nw: N-wide instruction fetch queue between imem and decode.
//   Fetches WIDTH consecutive instructions per cycle into a circular buffer
//   and presents the oldest WIDTH entries to decode. Decode consumes
//   0..WIDTH entries per cycle, so a stall on lane k holds lanes k and up.
//
// Ports:
//   clock          rising-edge clock
//   reset          async active-low reset
//   fetch_pc       base address of the current fetch group (lane i = +i)
//   fetch_en       imem read enable, all lanes
//   imem_data      WIDTH instructions, lane i at [i*INSTR_W +: INSTR_W]
//   redirect       flush queue and refetch from redirect_pc
//   redirect_pc    new fetch target
//   issue_count    entries consumed by decode this cycle
//   out_instr      oldest WIDTH entries, lane 0 = oldest
//   out_pc         PC of each presented entry
//   out_valid      thermometer, bit i = (count > i)
//   count          current occupancy
//   err_underflow  sticky, decode consumed more than was valid

// Per-lane output stage: forces invalid lanes to zero.
module fetch_queue_nw_lane #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 12
) (
   input  logic               valid,
   input  logic [INSTR_W-1:0] instr,
   input  logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] lane_instr,
   output logic [ADDR_W-1:0]  lane_pc
);
   assign lane_instr = valid ? instr : '0;
   assign lane_pc    = valid ? pc    : '0;
endmodule

module fetch_queue_nw #(
   parameter int WIDTH   = 2,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   output logic [ADDR_W-1:0]           fetch_pc,
   output logic                        fetch_en,
   input  logic [WIDTH*INSTR_W-1:0]    imem_data,
   input  logic                        redirect,
   input  logic [ADDR_W-1:0]           redirect_pc,
   input  logic [$clog2(WIDTH):0]      issue_count,
   output logic [WIDTH*INSTR_W-1:0]    out_instr,
   output logic [WIDTH*ADDR_W-1:0]     out_pc,
   output logic [WIDTH-1:0]            out_valid,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        err_underflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]      head, tail;
   logic [CW-1:0]      cnt;
   logic [ADDR_W-1:0]  pc_q;
   logic               err_q;

   logic [INSTR_W-1:0] q_instr [DEPTH];
   logic [ADDR_W-1:0]  q_pc    [DEPTH];

   logic [CW-1:0]      free_slots, issue_wide, ic_clamp, eff, enq_n;
   logic               uflow;

   // Fetch only with room for a whole group, judged on registered count so
   // a same-cycle dequeue never opens the gate.
   assign free_slots = CW'(DEPTH) - cnt;
   assign fetch_en   = reset && !redirect && (free_slots >= CW'(WIDTH));

   // Over-wide issue is clamped to WIDTH; both over-wide and over-count
   // requests flag underflow.
   assign issue_wide = CW'(issue_count);
   assign ic_clamp   = (issue_wide > CW'(WIDTH)) ? CW'(WIDTH) : issue_wide;
   assign eff        = (ic_clamp > cnt) ? cnt : ic_clamp;
   assign uflow      = (issue_wide > cnt) || (issue_wide > CW'(WIDTH));
   assign enq_n      = fetch_en ? CW'(WIDTH) : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         pc_q  <= '0;
         err_q <= 1'b0;
      end else if (redirect) begin
         // Flush: pending issue and this cycle's imem data are dropped.
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         pc_q <= redirect_pc;
      end else begin
         head <= head + eff[PW-1:0];
         cnt  <= cnt + enq_n - eff;
         if (uflow) err_q <= 1'b1;
         if (fetch_en) begin
            tail <= tail + PW'(WIDTH);
            pc_q <= pc_q + ADDR_W'(WIDTH);
         end
      end
   end

   // Storage carries no reset; fetch_en is already low while reset is held.
   always_ff @(posedge clock) begin
      if (fetch_en) begin
         for (int i = 0; i < WIDTH; i++) begin
            q_instr[tail + PW'(i)] <= imem_data[i*INSTR_W +: INSTR_W];
            q_pc[tail + PW'(i)]    <= pc_q + ADDR_W'(i);
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      logic [PW-1:0] rd_idx;
      assign rd_idx       = head + PW'(g);
      assign out_valid[g] = (cnt > CW'(g));
      fetch_queue_nw_lane #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_lane (
         .valid      (out_valid[g]),
         .instr      (q_instr[rd_idx]),
         .pc         (q_pc[rd_idx]),
         .lane_instr (out_instr[g*INSTR_W +: INSTR_W]),
         .lane_pc    (out_pc[g*ADDR_W +: ADDR_W])
      );
   end

   assign fetch_pc      = pc_q;
   assign count         = cnt;
   assign err_underflow = err_q;
endmodule
